// File: rtl/fb_port_arbiter_if.sv
// Bundle of scan-out, writer and frame-RAM port signals around fb_port_arbiter.
// The arbiter takes the slave view; the environment drives through the master view.
interface fb_port_arbiter_if #(
    parameter int DW  = 16,
    parameter int AW  = 17,
    parameter int QAW = 2
);
    logic          rd_en;
    logic [9:0]    active_x;
    logic [9:0]    active_y;
    logic          wr_valid;
    logic          wr_ready;
    logic [9:0]    wr_x;
    logic [9:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic          wr_drop;
    logic [QAW:0]  q_level;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;

    modport slave (
        input  rd_en, active_x, active_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata,
        output wr_ready, wr_drop, q_level, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
    );

    modport master (
        output rd_en, active_x, active_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata,
        input  wr_ready, wr_drop, q_level, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares one single-port frame RAM between display scan-out (strict priority) and a
// small FIFO of pixel writes that drains whenever scan-out leaves the port idle.
module fb_port_arbiter #(
    parameter int RD_H = 480,
    parameter int RD_V = 272,
    parameter int DW   = 16,
    parameter int AW   = 17,
    parameter int QAW  = 2
) (
    input logic              clk,
    input logic              rst,
    fb_port_arbiter_if.slave bus
);

    localparam int              DEPTH    = 1 << QAW;
    localparam logic [10:0]     H_LIM    = 11'(RD_H);
    localparam logic [10:0]     V_LIM    = 11'(RD_V);
    localparam logic [AW-1:0]   H_STRIDE = AW'(RD_H);
    localparam logic [QAW-1:0]  PTR_ONE  = QAW'(1'b1);
    localparam logic [QAW:0]    CNT_ONE  = (QAW+1)'(1'b1);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } port_op_e;

    logic [QAW-1:0] wr_ptr_r;
    logic [QAW-1:0] rd_ptr_r;
    logic [QAW:0]   count_r;
    logic [QAW:0]   count_nxt_s;
    logic [AW-1:0]  q_addr_r [DEPTH];
    logic [DW-1:0]  q_data_r [DEPTH];

    logic           wr_in_range_s;
    logic           rd_in_range_s;
    logic           wr_ready_s;
    logic           accept_s;
    logic           push_s;
    logic           drop_s;
    logic           pop_s;
    logic [AW-1:0]  wr_addr_s;
    logic [AW-1:0]  rd_addr_s;
    port_op_e       op_s;

    logic           wr_drop_r;
    logic [AW-1:0]  mem_addr_r;
    logic           mem_we_r;
    logic [DW-1:0]  mem_wdata_r;
    logic           rd_v1_r;
    logic           rd_oor1_r;
    logic           rd_v2_r;
    logic           rd_oor2_r;
    logic [DW-1:0]  pix_data_r;
    logic           pix_valid_r;

    assign wr_in_range_s = ({1'b0, bus.wr_x} < H_LIM) && ({1'b0, bus.wr_y} < V_LIM);
    assign rd_in_range_s = ({1'b0, bus.active_x} < H_LIM) && ({1'b0, bus.active_y} < V_LIM);
    assign wr_addr_s     = AW'(bus.wr_y) * H_STRIDE + AW'(bus.wr_x);
    assign rd_addr_s     = AW'(bus.active_y) * H_STRIDE + AW'(bus.active_x);

    // Count never exceeds DEPTH, so its MSB alone marks a full queue.
    assign wr_ready_s = ~count_r[QAW] & ~rst;
    assign accept_s   = bus.wr_valid & wr_ready_s;
    assign push_s     = accept_s & wr_in_range_s;
    assign drop_s     = accept_s & ~wr_in_range_s;

    // Port cycle decision: scan-out first, then a queued write, else idle.
    always_comb begin
        op_s  = OP_IDLE;
        pop_s = 1'b0;
        if (bus.rd_en) begin
            op_s = OP_READ;
        end else if (count_r != {(QAW+1){1'b0}}) begin
            op_s  = OP_WRITE;
            pop_s = 1'b1;
        end else begin
            op_s = OP_IDLE;
        end
    end

    // Occupancy after this edge; push and pop together cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Write queue storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {QAW{1'b0}};
            rd_ptr_r <= {QAW{1'b0}};
            count_r  <= {(QAW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= {AW{1'b0}};
                q_data_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (push_s) begin
                q_addr_r[wr_ptr_r] <= wr_addr_s;
                q_data_r[wr_ptr_r] <= bus.wr_data;
                wr_ptr_r           <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Drop pulse for accepted writes whose coordinates fall off the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_drop_r <= 1'b0;
        end else begin
            wr_drop_r <= drop_s;
        end
    end

    // Memory port registers driven by the chosen cycle type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r  <= {AW{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            case (op_s)
                OP_READ: begin
                    mem_we_r <= 1'b0;
                    if (rd_in_range_s) begin
                        mem_addr_r <= rd_addr_s;
                    end
                end
                OP_WRITE: begin
                    mem_addr_r  <= q_addr_r[rd_ptr_r];
                    mem_wdata_r <= q_data_r[rd_ptr_r];
                    mem_we_r    <= 1'b1;
                end
                OP_IDLE: begin
                    mem_we_r <= 1'b0;
                end
                default: begin
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    // Scan-out pipeline: address stage, RAM stage, output stage; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1_r     <= 1'b0;
            rd_oor1_r   <= 1'b0;
            rd_v2_r     <= 1'b0;
            rd_oor2_r   <= 1'b0;
            pix_data_r  <= {DW{1'b0}};
            pix_valid_r <= 1'b0;
        end else begin
            rd_v1_r     <= bus.rd_en;
            rd_oor1_r   <= bus.rd_en & ~rd_in_range_s;
            rd_v2_r     <= rd_v1_r;
            rd_oor2_r   <= rd_oor1_r;
            pix_valid_r <= rd_v2_r;
            pix_data_r  <= rd_oor2_r ? {DW{1'b0}} : bus.mem_rdata;
        end
    end

    assign bus.wr_ready  = wr_ready_s;
    assign bus.wr_drop   = wr_drop_r;
    assign bus.q_level   = count_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.pix_data  = pix_data_r;
    assign bus.pix_valid = pix_valid_r;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a pattern-filled frame RAM.
module tb_fb_port_arbiter;
    localparam int DW  = 16;
    localparam int AW  = 17;
    localparam int QAW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] rdata_r = 16'h0000;

    fb_port_arbiter_if #(.DW(DW), .AW(AW), .QAW(QAW)) bus();

    fb_port_arbiter #(.RD_H(480), .RD_V(272), .DW(DW), .AW(AW), .QAW(QAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    // Synchronous RAM: contents are a fixed function of the address.
    always @(posedge clk) rdata_r <= pat(bus.mem_addr);
    assign bus.mem_rdata = rdata_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.rd_en = 1'b0; bus.active_x = 10'd0; bus.active_y = 10'd0;
        bus.wr_valid = 1'b0; bus.wr_x = 10'd0; bus.wr_y = 10'd0; bus.wr_data = 16'h0000;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.wr_ready, bus.wr_drop, bus.q_level, bus.mem_we, bus.pix_valid} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0", {bus.wr_ready, bus.wr_drop, bus.q_level, bus.mem_we, bus.pix_valid});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.pix_data} !== 49'd0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.pix_data});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.q_level !== 3'd0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b level=%0d expected ready=1 level=0", bus.wr_ready, bus.q_level);
        end
    endtask

    task automatic test_scan_out();
        logic [15:0] exp_pix;
        bus.rd_en = 1'b1; bus.active_x = 10'd0; bus.active_y = 10'd1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 4) begin
                checks++;
                if (bus.mem_addr !== 17'((c <= 3) ? (480 + c - 1) : 482) || bus.mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL scan_addr c=%0d: got addr=%0d we=%b expected addr=%0d we=0", c, bus.mem_addr, bus.mem_we, (c <= 3) ? (480 + c - 1) : 482);
                end
            end
            checks++;
            if (bus.pix_valid !== ((c >= 3) && (c <= 6))) begin
                failures++;
                $display("FAIL scan_valid c=%0d: got %b expected %b", c, bus.pix_valid, (c >= 3) && (c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                exp_pix = (c == 6) ? 16'h0000 : pat(17'(480 + c - 3));
                checks++;
                if (bus.pix_data !== exp_pix) begin
                    failures++;
                    $display("FAIL scan_pix c=%0d: got %h expected %h", c, bus.pix_data, exp_pix);
                end
            end
            if (c < 3) bus.active_x = 10'(c);
            else if (c == 3) bus.active_x = 10'd600;
            else bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_write_gap();
        drive_idle();
        bus.wr_valid = 1'b1; bus.wr_x = 10'd10; bus.wr_y = 10'd2; bus.wr_data = 16'hABCD;
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.q_level !== 3'd1) begin
            failures++;
            $display("FAIL gap_queued: got we=%b level=%0d expected we=0 level=1", bus.mem_we, bus.q_level);
        end
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'd970 || bus.mem_wdata !== 16'hABCD || bus.q_level !== 3'd0) begin
            failures++;
            $display("FAIL gap_write: got we=%b addr=%0d data=%h level=%0d expected we=1 addr=970 data=abcd level=0", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.q_level);
        end
        tick();
        checks++;
        if (bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL gap_after: got we=%b expected 0", bus.mem_we);
        end
    endtask

    task automatic test_out_of_range();
        drive_idle();
        bus.wr_valid = 1'b1; bus.wr_x = 10'd480; bus.wr_y = 10'd0; bus.wr_data = 16'h1111;
        tick();
        bus.wr_x = 10'd0; bus.wr_y = 10'd272;
        checks++;
        if (bus.wr_drop !== 1'b1 || bus.q_level !== 3'd0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL oor_x: got drop=%b level=%0d we=%b expected drop=1 level=0 we=0", bus.wr_drop, bus.q_level, bus.mem_we);
        end
        tick();
        bus.wr_x = 10'd479; bus.wr_y = 10'd271; bus.wr_data = 16'h7E57;
        checks++;
        if (bus.wr_drop !== 1'b1 || bus.q_level !== 3'd0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL oor_y: got drop=%b level=%0d we=%b expected drop=1 level=0 we=0", bus.wr_drop, bus.q_level, bus.mem_we);
        end
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.wr_drop !== 1'b0 || bus.q_level !== 3'd1) begin
            failures++;
            $display("FAIL edge_accept: got drop=%b level=%0d expected drop=0 level=1", bus.wr_drop, bus.q_level);
        end
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'd130559 || bus.mem_wdata !== 16'h7E57) begin
            failures++;
            $display("FAIL edge_write: got we=%b addr=%0d data=%h expected we=1 addr=130559 data=7e57", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL oor_quiet: got we=%b drop=%b expected 0 0", bus.mem_we, bus.wr_drop);
        end
    endtask

    task automatic test_priority_backpressure();
        int   sent;
        logic acc;
        logic [2:0] exp_lvl [6];
        exp_lvl = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            bus.rd_en = 1'b1; bus.active_x = 10'(c); bus.active_y = 10'd0;
            bus.wr_valid = (sent < 6); bus.wr_x = 10'(sent); bus.wr_y = 10'd5;
            bus.wr_data = 16'h1000 + 16'(sent);
            acc = bus.wr_valid && bus.wr_ready;
            tick();
            if (acc) sent++;
            checks++;
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== 17'(c)) begin
                failures++;
                $display("FAIL prio_read c=%0d: got we=%b addr=%0d expected we=0 addr=%0d", c, bus.mem_we, bus.mem_addr, c);
            end
            checks++;
            if (bus.q_level !== 3'((c < 3) ? c + 1 : 4) || bus.wr_ready !== (c < 3)) begin
                failures++;
                $display("FAIL prio_fill c=%0d: got level=%0d ready=%b expected level=%0d ready=%b", c, bus.q_level, bus.wr_ready, (c < 3) ? c + 1 : 4, c < 3);
            end
        end
        for (int k = 0; k < 7; k++) begin
            bus.rd_en = 1'b0;
            bus.wr_valid = (sent < 6); bus.wr_x = 10'(sent); bus.wr_y = 10'd5;
            bus.wr_data = 16'h1000 + 16'(sent);
            acc = bus.wr_valid && bus.wr_ready;
            tick();
            if (acc) sent++;
            checks++;
            if (k < 6) begin
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'(2400 + k) || bus.mem_wdata !== 16'h1000 + 16'(k) || bus.q_level !== exp_lvl[k]) begin
                    failures++;
                    $display("FAIL drain k=%0d: got we=%b addr=%0d data=%h level=%0d expected we=1 addr=%0d data=%h level=%0d", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.q_level, 2400 + k, 16'h1000 + 16'(k), exp_lvl[k]);
                end
            end else if (bus.mem_we !== 1'b0) begin
                failures++;
                $display("FAIL drain_end: got we=%b expected 0", bus.mem_we);
            end
        end
    endtask

    task automatic test_enqueue_pop();
        drive_idle();
        for (int k = 0; k < 7; k++) begin
            bus.wr_valid = (k < 5); bus.wr_x = 10'(k); bus.wr_y = 10'd7;
            bus.wr_data = 16'h2000 + 16'(k);
            tick();
            checks++;
            if (k == 0) begin
                if (bus.q_level !== 3'd1 || bus.mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_first: got level=%0d we=%b expected level=1 we=0", bus.q_level, bus.mem_we);
                end
            end else if (k <= 5) begin
                if (bus.q_level !== 3'((k < 5) ? 1 : 0) || bus.mem_we !== 1'b1 || bus.mem_addr !== 17'(3360 + k - 1) || bus.mem_wdata !== 16'h2000 + 16'(k - 1)) begin
                    failures++;
                    $display("FAIL stream k=%0d: got level=%0d we=%b addr=%0d data=%h expected level=%0d we=1 addr=%0d", k, bus.q_level, bus.mem_we, bus.mem_addr, bus.mem_wdata, (k < 5) ? 1 : 0, 3360 + k - 1);
                end
            end else if (bus.mem_we !== 1'b0) begin
                failures++;
                $display("FAIL stream_end: got we=%b expected 0", bus.mem_we);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive_idle();
        bus.rd_en = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_y = 10'd9; bus.wr_data = 16'h3333;
        for (int k = 0; k < 4; k++) begin
            bus.wr_x = 10'(k);
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.q_level !== 3'd4 || bus.wr_ready !== 1'b0 || bus.pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_full: got level=%0d ready=%b pv=%b expected level=4 ready=0 pv=1", bus.q_level, bus.wr_ready, bus.pix_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_ready, bus.wr_drop, bus.q_level, bus.mem_we, bus.pix_valid} !== 7'd0 || {bus.mem_addr, bus.mem_wdata, bus.pix_data} !== 49'd0) begin
            failures++;
            $display("FAIL mid_reset: got ctrl=%b data=%h expected 0", {bus.wr_ready, bus.wr_drop, bus.q_level, bus.mem_we, bus.pix_valid}, {bus.mem_addr, bus.mem_wdata, bus.pix_data});
        end
        bus.rd_en = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.q_level !== 3'd0) begin
            failures++;
            $display("FAIL mid_release: got ready=%b level=%0d expected ready=1 level=0", bus.wr_ready, bus.q_level);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.mem_we !== 1'b0 || bus.q_level !== 3'd0) begin
                failures++;
                $display("FAIL mid_stale k=%0d: got we=%b level=%0d expected we=0 level=0", k, bus.mem_we, bus.q_level);
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_scan_out();
        test_write_gap();
        test_out_of_range();
        test_priority_backpressure();
        test_enqueue_pop();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
